alu_share_arbiter: RTL and testbench

Shares the single integer ALU between two requesters: port 0 is the main execute path and port 1 is the auxiliary address/compare path. The block arbitrates round-robin and registers the winning operation into the ALU inputs. It captures the ALU result one cycle later and returns it to the owning requester with a valid/ready handshake. It sits between the ALU control unit outputs and the ALU; the ALU itself stays combinational and outside this block.

---
 rtl/alu_share_arbiter.sv | 109 ++++++++++
 tb/tb_alu_share_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters.
// Two stages: ISSUE registers the winning operation into the ALU inputs, RESP captures the result.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [SEL_W-1:0] req1_sel,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [SEL_W-1:0] alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);

    // Handshakes: a transfer happens in a cycle where valid && ready are both high.
    // ready never depends on ready from the other side of the same channel, and a
    // stalled response (valid && !ready) holds rsp_data and freezes the whole pipe.

    logic iss_v;
    logic iss_own;
    logic rsp_v;
    logic rsp_own;
    logic rr_last;

    logic rsp_stall;
    logic advance;
    logic g0;
    logic g1;
    logic acc0;
    logic acc1;

    always_comb begin
        rsp_stall = rsp_v && !(rsp_own ? rsp1_ready : rsp0_ready);
        advance   = !rsp_stall;
        // On a tie the port that did not win last gets the grant.
        g0        = req0_valid && (!req1_valid || rr_last);
        g1        = req1_valid && (!req0_valid || !rr_last);
    end

    assign req0_ready = advance && g0;
    assign req1_ready = advance && g1;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_v   <= 1'b0;
            iss_own <= 1'b0;
            rr_last <= 1'b1;
            alu_sel <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
        end else if (advance) begin
            if (acc0) begin
                alu_sel <= req0_sel;
                alu_a   <= req0_a;
                alu_b   <= req0_b;
                iss_v   <= 1'b1;
                iss_own <= 1'b0;
                rr_last <= 1'b0;
            end else if (acc1) begin
                alu_sel <= req1_sel;
                alu_a   <= req1_a;
                alu_b   <= req1_b;
                iss_v   <= 1'b1;
                iss_own <= 1'b1;
                rr_last <= 1'b1;
            end else begin
                // ALU inputs keep their last values to avoid needless toggling.
                iss_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_v    <= 1'b0;
            rsp_own  <= 1'b0;
            rsp_data <= '0;
        end else if (advance) begin
            rsp_v   <= iss_v;
            rsp_own <= iss_own;
            if (iss_v) begin
                rsp_data <= alu_result;
            end
        end
    end

    assign rsp0_valid = rsp_v && !rsp_own;
    assign rsp1_valid = rsp_v && rsp_own;
    assign busy       = iss_v || rsp_v;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU (0 = add, 1 = sub).
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;
    localparam int SEL_W = 4;
    localparam logic [SEL_W-1:0] ALU_ADD = 4'h0;
    localparam logic [SEL_W-1:0] ALU_SUB = 4'h1;

    logic             clk;
    logic             rst;
    logic             req0_valid, req0_ready;
    logic [SEL_W-1:0] req0_sel;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready;
    logic [SEL_W-1:0] req1_sel;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic             rsp0_valid, rsp0_ready;
    logic             rsp1_valid, rsp1_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [SEL_W-1:0] alu_sel;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             busy;

    int checks = 0;
    int errors = 0;

    alu_share_arbiter #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .busy(busy)
    );

    assign alu_result = (alu_sel == ALU_SUB) ? alu_a - alu_b : alu_a + alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req0_valid = v; req0_sel = s; req0_a = a; req0_b = b;
    endtask

    task automatic drive1(input logic v, input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req1_valid = v; req1_sel = s; req1_a = a; req1_b = b;
    endtask

    initial begin
        rst = 1'b1;
        drive0(1'b0, ALU_ADD, '0, '0);
        drive1(1'b0, ALU_ADD, '0, '0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #12;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
        chk("reset_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
        chk("reset_alu_a", alu_a, 32'd0);
        chk("reset_alu_sel", {28'b0, alu_sel}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single op on port 0: 5 + 3, latency 2.
        next_cycle();
        drive0(1'b1, ALU_ADD, 32'd5, 32'd3);
        #1;
        chk("t1_req0_ready", {31'b0, req0_ready}, 32'd1);
        chk("t1_req1_ready", {31'b0, req1_ready}, 32'd0);
        next_cycle();
        drive0(1'b0, ALU_ADD, '0, '0);
        #1;
        chk("t1_alu_a", alu_a, 32'd5);
        chk("t1_alu_b", alu_b, 32'd3);
        chk("t1_early_rsp0", {31'b0, rsp0_valid}, 32'd0);
        chk("t1_busy_issue", {31'b0, busy}, 32'd1);
        next_cycle();
        #1;
        chk("t1_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
        chk("t1_rsp_data", rsp_data, 32'd8);
        chk("t1_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
        // Idle gap: ALU inputs hold, pipe empties.
        next_cycle();
        #1;
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
        chk("idle_alu_a", alu_a, 32'd5);
        chk("idle_alu_b", alu_b, 32'd3);
        chk("idle_alu_sel", {28'b0, alu_sel}, {28'b0, ALU_ADD});

        // Wrap-around passthrough on port 1: 0 - 1.
        next_cycle();
        drive1(1'b1, ALU_SUB, 32'd0, 32'd1);
        #1;
        chk("wrap_req1_ready", {31'b0, req1_ready}, 32'd1);
        next_cycle();
        drive1(1'b0, ALU_ADD, '0, '0);
        #1;
        chk("wrap_early_rsp1", {31'b0, rsp1_valid}, 32'd0);
        next_cycle();
        #1;
        chk("wrap_rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
        chk("wrap_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
        chk("wrap_rsp_data", rsp_data, 32'hFFFF_FFFF);
        next_cycle();

        // Backpressure: 7 + 7 for port 0 stalls three cycles while 10 - 4 waits in ISSUE.
        drive0(1'b1, ALU_ADD, 32'd7, 32'd7);
        rsp0_ready = 1'b0;
        #1;
        chk("bp_req0_ready", {31'b0, req0_ready}, 32'd1);
        next_cycle();
        drive0(1'b0, ALU_ADD, '0, '0);
        drive1(1'b1, ALU_SUB, 32'd10, 32'd4);
        #1;
        chk("bp_req1_ready", {31'b0, req1_ready}, 32'd1);
        next_cycle();
        drive0(1'b1, ALU_ADD, 32'd1, 32'd1);
        drive1(1'b1, ALU_ADD, 32'd2, 32'd2);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
            chk("bp_rsp_data", rsp_data, 32'd14);
            chk("bp_alu_sel", {28'b0, alu_sel}, {28'b0, ALU_SUB});
            chk("bp_alu_a", alu_a, 32'd10);
            chk("bp_alu_b", alu_b, 32'd4);
            chk("bp_req0_blocked", {31'b0, req0_ready}, 32'd0);
            chk("bp_req1_blocked", {31'b0, req1_ready}, 32'd0);
            next_cycle();
        end
        drive0(1'b0, ALU_ADD, '0, '0);
        drive1(1'b0, ALU_ADD, '0, '0);
        rsp0_ready = 1'b1;
        #1;
        chk("bp_drain_rsp0", {31'b0, rsp0_valid}, 32'd1);
        chk("bp_drain_data", rsp_data, 32'd14);
        next_cycle();
        #1;
        chk("bp_rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
        chk("bp_rsp1_data", rsp_data, 32'd6);
        next_cycle();
        #1;
        chk("bp_busy_clear", {31'b0, busy}, 32'd0);

        // Reset mid-flight: two ops in flight, rst raised between edges.
        next_cycle();
        drive0(1'b1, ALU_ADD, 32'd1, 32'd1);
        drive1(1'b1, ALU_SUB, 32'd10, 32'd4);
        #1;
        chk("mf_first_grant0", {31'b0, req0_ready}, 32'd1);
        next_cycle();
        #1;
        chk("mf_second_grant1", {31'b0, req1_ready}, 32'd1);
        next_cycle();
        drive0(1'b0, ALU_ADD, '0, '0);
        drive1(1'b0, ALU_ADD, '0, '0);
        #1;
        chk("mf_busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mf_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
        chk("mf_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
        chk("mf_busy", {31'b0, busy}, 32'd0);
        chk("mf_alu_a", alu_a, 32'd0);
        chk("mf_alu_b", alu_b, 32'd0);
        chk("mf_alu_sel", {28'b0, alu_sel}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            #1;
            chk("mf_no_stale_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
            chk("mf_no_stale_busy", {31'b0, busy}, 32'd0);
        end

        // Continuous dual requests from reset: grants and responses alternate.
        next_cycle();
        drive0(1'b1, ALU_ADD, 32'd1, 32'd1);
        drive1(1'b1, ALU_SUB, 32'd10, 32'd4);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("alt_req0_ready", {31'b0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("alt_req1_ready", {31'b0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i >= 2) begin
                chk("alt_rsp0_valid", {31'b0, rsp0_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
                chk("alt_rsp1_valid", {31'b0, rsp1_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
                chk("alt_rsp_data", rsp_data, (i % 2 == 0) ? 32'd2 : 32'd6);
            end else begin
                chk("alt_no_rsp_yet", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
            end
            next_cycle();
        end
        drive0(1'b0, ALU_ADD, '0, '0);
        drive1(1'b0, ALU_ADD, '0, '0);
        #1;
        chk("alt_tail_rsp0", {31'b0, rsp0_valid}, 32'd1);
        chk("alt_tail_data0", rsp_data, 32'd2);
        next_cycle();
        #1;
        chk("alt_tail_rsp1", {31'b0, rsp1_valid}, 32'd1);
        chk("alt_tail_data1", rsp_data, 32'd6);
        next_cycle();
        #1;
        chk("alt_final_busy", {31'b0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
